// File: rtl/sram_access_controller.sv
// Data-memory initiator: splits a 32-bit MEM-stage access into
// two halfword phases on an external asynchronous SRAM.
module sram_access_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_w_en,
  input  logic               mem_r_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [31:0] BASE     = 32'(BASE_ADDR);
  localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [3:0]         cnt;
  logic [3:0]         cnt_nx;
  logic               op_w;
  logic [SRAM_AW-2:0] word;
  logic [SRAM_AW-2:0] word_nx;
  logic [31:0]        wdata;
  logic [31:0]        offs;
  logic               req;
  logic               last;

  assign req     = mem_w_en | mem_r_en;
  assign offs    = alu_res - BASE;
  assign word_nx = (SRAM_AW-1)'(offs >> 2);
  assign last    = (cnt == CNT_LAST);

  // State, phase counter, latched request and load-result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_w  <= 1'b0;
      word  <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        op_w  <= mem_w_en;
        word  <= word_nx;
        wdata <= val_rm;
      end
      if (state == LO && !op_w && last)
        rdata[15:0] <= sram_dq_i;
      if (state == HI && !op_w && last)
        rdata[31:16] <= sram_dq_i;
    end
  end

  // Next state and SRAM strobes; strobes decode from state only so
  // an asynchronous reset releases them at once
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    unique case (state)
      IDLE: begin
        ready = ~req | ~rst;
        if (req) begin
          state_nx = LO;
          cnt_nx   = '0;
        end
      end
      LO: begin
        sram_addr = {word, 1'b0};
        if (op_w) begin
          sram_dq_oe = 1'b1;
          sram_dq_o  = wdata[15:0];
          sram_we_n  = 1'b0;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (last) begin
          cnt_nx   = '0;
          state_nx = HI;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HI: begin
        sram_addr = {word, 1'b1};
        if (op_w) begin
          sram_dq_oe = 1'b1;
          sram_dq_o  = wdata[31:16];
          sram_we_n  = 1'b0;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (last) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller with a halfword SRAM
// model and a scoreboard of expected writes and load results.
module tb_sram_access_controller;

  logic        clk;
  logic        rst;
  logic        mem_w_en;
  logic        mem_r_en;
  logic [31:0] alu_res;
  logic [31:0] val_rm;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  logic        w1;
  logic        r1;
  logic [31:0] a1;
  logic [31:0] v1;
  logic [31:0] rdata1;
  logic        rdy1;
  logic [17:0] addr1;
  logic [15:0] dqo1;
  logic [15:0] dqi1;
  logic        dqoe1;
  logic        we_n1;
  logic        oe_n1;

  logic [15:0] mem [0:63];
  logic [17:0] wa_q[$];
  logic [15:0] wd_q[$];
  logic [31:0] rd_q[$];
  logic        prev_we;
  logic [17:0] prev_addr;
  int          wcyc;
  int          checks;
  int          failures;

  sram_access_controller #(
    .BASE_ADDR(1024), .WAIT_CYCLES(2), .SRAM_AW(18)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .alu_res(alu_res), .val_rm(val_rm),
    .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_access_controller #(
    .BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)
  ) dut1 (
    .clk(clk), .rst(rst),
    .mem_w_en(w1), .mem_r_en(r1),
    .alu_res(a1), .val_rm(v1),
    .rdata(rdata1), .ready(rdy1),
    .sram_addr(addr1), .sram_dq_o(dqo1),
    .sram_dq_i(dqi1), .sram_dq_oe(dqoe1),
    .sram_we_n(we_n1), .sram_oe_n(oe_n1)
  );

  assign sram_dq_i = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];
  assign dqi1      = 16'hA5C3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sample point: mid-cycle; write monitor pops the scoreboard
  // at the start of each write phase and updates the SRAM model
  task automatic smp();
    @(negedge clk);
    if (!sram_we_n && (prev_we || sram_addr != prev_addr)) begin
      checks++;
      assert (wa_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%h expected=none",
               sram_addr);
      end
      if (wa_q.size() != 0) begin
        chk("wr_addr", 32'(sram_addr), 32'(wa_q.pop_front()));
        chk("wr_data", 32'(sram_dq_o), 32'(wd_q.pop_front()));
      end
    end
    if (!sram_we_n) begin
      wcyc++;
      mem[sram_addr[5:0]] = sram_dq_o;
    end
    prev_we   = sram_we_n;
    prev_addr = sram_addr;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(logic [17:0] a, logic [15:0] d);
    wa_q.push_back(a);
    wd_q.push_back(d);
  endtask

  initial begin
    int lowc;
    int wc0;
    logic [17:0] ea;
    checks    = 0;
    failures  = 0;
    wcyc      = 0;
    prev_we   = 1'b1;
    prev_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'(16'h1000 + i);
    mem[2] = 16'h1111;
    mem[3] = 16'h2222;
    w1 = 0; r1 = 0; a1 = 0; v1 = 0;

    // reset with a write request pending
    rst      = 1'b0;
    mem_w_en = 1'b1;
    mem_r_en = 1'b0;
    alu_res  = 32'd1032;
    val_rm   = 32'hDEADBEEF;
    push_w(18'd4, 16'hBEEF);
    push_w(18'd5, 16'hDEAD);
    repeat (2) adv();
    smp();
    chk("rst_ready", ready, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", 32'(sram_addr), 0);
    adv();
    rst = 1'b1;

    // write 0xDEADBEEF at 1032, held through DONE
    for (int c = 0; c <= 5; c++) begin
      smp();
      ea = (c == 1 || c == 2) ? 18'd4 :
           (c == 3 || c == 4) ? 18'd5 : 18'd0;
      chk("wr_ready", ready, 32'(c == 5));
      chk("wr_we_n", sram_we_n, 32'(c == 0 || c == 5));
      chk("wr_oe_n", sram_oe_n, 1);
      chk("wr_addr_c", 32'(sram_addr), 32'(ea));
      adv();
    end

    // back-to-back read at 1028
    wc0      = wcyc;
    mem_w_en = 1'b0;
    mem_r_en = 1'b1;
    alu_res  = 32'd1028;
    rd_q.push_back(32'h22221111);
    for (int c = 0; c <= 5; c++) begin
      smp();
      ea = (c == 1 || c == 2) ? 18'd2 :
           (c == 3 || c == 4) ? 18'd3 : 18'd0;
      chk("b2b_ready", ready, 32'(c == 5));
      chk("b2b_oe_n", sram_oe_n, 32'(c == 0 || c == 5));
      chk("b2b_addr", 32'(sram_addr), 32'(ea));
      if (c == 5) chk("b2b_rdata", rdata, rd_q.pop_front());
      adv();
    end
    chk("b2b_no_write", 32'(wcyc - wc0), 0);
    chk("wr_cycles", 32'(wcyc), 4);
    mem_r_en = 1'b0;
    smp();
    chk("idle_ready", ready, 1);
    adv();

    // read back 1032 from the SRAM model
    mem_r_en = 1'b1;
    alu_res  = 32'd1032;
    rd_q.push_back(32'hDEADBEEF);
    lowc = 0;
    for (int c = 0; c <= 5; c++) begin
      smp();
      if (!ready) lowc++;
      chk("rd_oe_n", sram_oe_n, 32'(c == 0 || c == 5));
      chk("rd_we_n", sram_we_n, 1);
      if (c == 5) chk("rd_rdata", rdata, rd_q.pop_front());
      adv();
    end
    chk("rd_low_cycles", 32'(lowc), 5);
    mem_r_en = 1'b0;

    // both enables: write wins, rdata untouched
    mem_w_en = 1'b1;
    mem_r_en = 1'b1;
    alu_res  = 32'd1024;
    val_rm   = 32'h12345678;
    push_w(18'd0, 16'h5678);
    push_w(18'd1, 16'h1234);
    wc0 = wcyc;
    for (int c = 0; c <= 5; c++) begin
      smp();
      chk("both_oe_n", sram_oe_n, 1);
      chk("both_ready", ready, 32'(c == 5));
      if (c == 5) chk("both_rdata", rdata, 32'hDEADBEEF);
      adv();
    end
    chk("both_wcyc", 32'(wcyc - wc0), 4);
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
    adv();

    // WAIT_CYCLES = 1: write then read, 3 low cycles each
    w1 = 1'b1;
    a1 = 32'd1024;
    v1 = 32'hCAFE0123;
    lowc = 0;
    for (int c = 0; c <= 3; c++) begin
      smp();
      if (!rdy1) lowc++;
      chk("w1_we_n", we_n1, 32'(c == 0 || c == 3));
      chk("w1_addr", 32'(addr1), 32'(c == 2));
      chk("w1_dq", 32'(dqo1), c == 1 ? 32'h0123 :
                              c == 2 ? 32'hCAFE : 32'h0);
      adv();
    end
    chk("w1_low_cycles", 32'(lowc), 3);
    w1 = 1'b0;
    r1 = 1'b1;
    rd_q.push_back(32'hA5C3A5C3);
    lowc = 0;
    for (int c = 0; c <= 3; c++) begin
      smp();
      if (!rdy1) lowc++;
      chk("r1_oe_n", oe_n1, 32'(c == 0 || c == 3));
      if (c == 3) chk("r1_rdata", rdata1, rd_q.pop_front());
      adv();
    end
    chk("r1_low_cycles", 32'(lowc), 3);
    r1 = 1'b0;
    adv();

    // reset in the first HI cycle of a write
    mem_w_en = 1'b1;
    alu_res  = 32'd1032;
    val_rm   = 32'h0BADF00D;
    push_w(18'd4, 16'hF00D);
    push_w(18'd5, 16'h0BAD);
    for (int c = 0; c <= 2; c++) begin
      smp();
      adv();
    end
    smp();
    chk("mid_we_n_before", sram_we_n, 0);
    #1;
    rst      = 1'b0;
    mem_w_en = 1'b0;
    #1;
    chk("mid_we_n_async", sram_we_n, 1);
    chk("mid_dq_oe_async", sram_dq_oe, 0);
    adv();
    rst = 1'b1;
    smp();
    chk("post_ready", ready, 1);
    chk("post_we_n", sram_we_n, 1);
    chk("post_addr", 32'(sram_addr), 0);
    adv();
    smp();
    chk("post_ready2", ready, 1);
    chk("post_oe_n", sram_oe_n, 1);
    chk("wq_drained", 32'(wa_q.size()), 0);
    chk("rq_drained", 32'(rd_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
- Initiator side of the data-memory path: takes the MEM-stage request (read/write enable, ALU result address, store data) and runs it as two 16-bit halfword accesses on an external SRAM.
- Returns a 32-bit load result and a ready flag; the hazard/freeze logic stalls the pipeline while ready is low.
- Address mapping matches the existing data memory: word address = (address − BASE_ADDR) >> 2.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles each halfword phase lasts. Legal range is 1..15.
- SRAM_AW, 18: SRAM address width in halfwords.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- mem_w_en  in  1  store request from the MEM stage
- mem_r_en  in  1  load request from the MEM stage
- alu_res  in  32  byte address
- val_rm  in  32  store data
- rdata  out  32  load result
- ready  out  1  request complete or idle; freeze = ~ready
- sram_addr  out  SRAM_AW  halfword address
- sram_dq_o  out  16  write data to SRAM
- sram_dq_i  in  16  read data from SRAM
- sram_dq_oe  out  1  data bus drive enable
- sram_we_n  out  1  write strobe, active low
- sram_oe_n  out  1  output enable, active low

Behaviour:
- Reset values (rst low, takes effect immediately, asynchronous):
  - state = IDLE, cnt = 0, rdata = 0.
  - sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_o = 0.
- Reset mid-operation aborts the access. sram_we_n rises without waiting for a clock edge. No partial-result guarantee.
- State machine: IDLE → LO → HI → DONE → IDLE.
- IDLE:
  - ready = ~(mem_w_en | mem_r_en). This is combinational, so freeze asserts in the same cycle as the request.
  - On a request, the clock edge latches: the op (write wins if both enables are high), word = (alu_res − BASE_ADDR) >> 2 truncated to SRAM_AW−1 bits, and val_rm. It then clears cnt and moves to LO.
  - In IDLE, SRAM outputs hold their reset values.
- LO phase:
  - sram_addr = {word, 1'b0}.
  - Write: sram_dq_oe = 1, sram_dq_o = wdata[15:0], sram_we_n = 0.
  - Read: sram_oe_n = 0. The edge ending the phase (cnt == WAIT_CYCLES−1) captures sram_dq_i into rdata[15:0].
  - cnt increments each cycle. At WAIT_CYCLES−1, cnt clears and the state moves to HI.
- HI phase: same as LO, with sram_addr = {word, 1'b1}, wdata[31:16], and capture into rdata[31:16].
- DONE: lasts one cycle.
  - ready = 1, all strobes inactive, rdata valid.
  - Requests seen in DONE belong to the completing instruction and are ignored. The next cycle is always IDLE.
- Latency: request first seen in IDLE at cycle 0.
  - LO occupies cycles 1..W, HI occupies W+1..2W, DONE is cycle 2W+1.
  - ready is low for cycles 0..2W, i.e. 2W+1 cycles.
- rdata holds its value until the next read completes; writes do not modify it.
- Address arithmetic is modulo 2^32. Out-of-range addresses wrap by truncation; there is no error.
- Request enables changing during LO/HI are ignored; the latched op completes.

Test Plan:
- Reset: assert rst low for 3 cycles with mem_w_en = 1 → ready = 1 (after rst rises ready = 0), sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, rdata = 0, sram_addr = 0.
- Write, W = 2: alu_res = 1032, val_rm = 0xDEADBEEF, mem_w_en held →
  - cycles 1–2: sram_addr = 4, dq_o = 0xBEEF, we_n = 0.
  - cycles 3–4: sram_addr = 5, dq_o = 0xDEAD, we_n = 0.
  - cycle 5: ready = 1, we_n = 1.
  - ready = 0 in cycles 0–4.
- Read back: behavioural SRAM model holding the above data, alu_res = 1032, mem_r_en → oe_n = 0 in cycles 1–4, rdata = 0xDEADBEEF in cycle 5, ready low for exactly 5 cycles.
- Simultaneous mem_w_en = mem_r_en = 1, alu_res = 1024, val_rm = 0x12345678 → write performed: addresses 0/1 with 0x5678/0x1234, we_n pulses, oe_n stays 1, rdata unchanged.
- Back-to-back: write held through DONE, then a read at 1028 in the following cycle → no second write is issued in DONE. The read starts from IDLE with sram_addr = 2 then 3. WAIT_CYCLES = 1 variant: ready low for 3 cycles per access.
- Reset mid-write: rst low during cycle 3 of a W = 2 write → sram_we_n = 1 and sram_dq_oe = 0 before the next edge. After release: state IDLE, ready = 1 with no request pending.
